// File: rtl/seq_controller.sv
`default_nettype none
// ============================================================================
// Module      : seq_controller
// Description : Multi-cycle sequencer for a Y86-style datapath. It walks
//               FETCH -> DECODE -> EXECUTE -> MEMORY -> WRITEBACK -> PCUPD,
//               handshakes with data memory (with a bounded wait), and stops
//               in HALT on a fetch fault, a memory error or a memory timeout.
//               The optional performance counters are enabled by defining
//               SEQ_CTRL_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_controller #(
    parameter logic [63:0] START_PC    = 64'd0,
    parameter int          MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  stat_f,
    input  logic [3:0]  icode,
    input  logic        cnd,
    input  logic [63:0] valC,
    input  logic [63:0] valP,
    input  logic [63:0] valM,
    input  logic        m_ack,
    input  logic        m_err,
    output logic [63:0] PC,
    output logic        d_en,
    output logic        e_en,
    output logic        w_en,
    output logic        m_req,
    output logic [3:0]  stat,
    output logic        busy,
    output logic        halted,
    output logic [31:0] instr_cnt,
    output logic [31:0] cycle_cnt
);

    localparam int         c_STATE_W   = 3;
    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_FETCH     = 3'd1;
    localparam logic [2:0] c_DECODE    = 3'd2;
    localparam logic [2:0] c_EXECUTE   = 3'd3;
    localparam logic [2:0] c_MEMORY    = 3'd4;
    localparam logic [2:0] c_WRITEBACK = 3'd5;
    localparam logic [2:0] c_PCUPD     = 3'd6;
    localparam logic [2:0] c_HALT      = 3'd7;

    localparam logic [3:0] c_STAT_AOK  = 4'd0;
    localparam logic [3:0] c_STAT_ADR  = 4'd2;

    // Wait-counter value at which the current no-ack cycle is the last allowed one
    localparam logic [7:0] c_WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    logic [c_STATE_W-1:0] r_state;
    logic [63:0]          r_pc;
    logic [3:0]           r_stat;
    logic                 r_d_en;
    logic                 r_e_en;
    logic                 r_w_en;
    logic                 r_m_req;
    logic                 r_busy;
    logic                 r_halted;
    logic [7:0]           r_wait;
    logic                 w_mem_op;
    logic [63:0]          w_next_pc;

    // Instruction classes that touch data memory
    always_comb begin
        w_mem_op = (icode == 4'd4) || (icode == 4'd5) || (icode == 4'd8) ||
                   (icode == 4'd9) || (icode == 4'd10) || (icode == 4'd11);
    end

    // Next-PC selection: call and taken jump use valC, ret uses valM
    always_comb begin
        w_next_pc = valP;
        if ((icode == 4'd8) || ((icode == 4'd7) && cnd)) begin
            w_next_pc = valC;
        end else if (icode == 4'd9) begin
            w_next_pc = valM;
        end
    end

    // Sequencer: state plus all outputs registered on the transition into each state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= c_IDLE;
            r_pc     <= START_PC;
            r_stat   <= c_STAT_AOK;
            r_d_en   <= 1'b0;
            r_e_en   <= 1'b0;
            r_w_en   <= 1'b0;
            r_m_req  <= 1'b0;
            r_busy   <= 1'b0;
            r_halted <= 1'b0;
            r_wait   <= 8'd0;
        end else begin
            r_d_en <= 1'b0;
            r_e_en <= 1'b0;
            r_w_en <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_state <= c_FETCH;
                        r_busy  <= 1'b1;
                    end
                end
                c_FETCH: begin
                    if (stat_f == c_STAT_AOK) begin
                        r_state <= c_DECODE;
                        r_d_en  <= 1'b1;
                    end else begin
                        r_state  <= c_HALT;
                        r_stat   <= stat_f;
                        r_busy   <= 1'b0;
                        r_halted <= 1'b1;
                    end
                end
                c_DECODE: begin
                    r_state <= c_EXECUTE;
                    r_e_en  <= 1'b1;
                end
                c_EXECUTE: begin
                    r_state <= c_MEMORY;
                    r_m_req <= w_mem_op;
                    r_wait  <= 8'd0;
                end
                c_MEMORY: begin
                    if (!r_m_req) begin
                        r_state <= c_WRITEBACK;
                        r_w_en  <= 1'b1;
                    end else if (m_ack) begin
                        // An ack in the final wait cycle still completes the access
                        r_m_req <= 1'b0;
                        if (m_err) begin
                            r_state  <= c_HALT;
                            r_stat   <= c_STAT_ADR;
                            r_busy   <= 1'b0;
                            r_halted <= 1'b1;
                        end else begin
                            r_state <= c_WRITEBACK;
                            r_w_en  <= 1'b1;
                        end
                    end else if (r_wait == c_WAIT_LAST) begin
                        r_m_req  <= 1'b0;
                        r_state  <= c_HALT;
                        r_stat   <= c_STAT_ADR;
                        r_busy   <= 1'b0;
                        r_halted <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                c_WRITEBACK: begin
                    r_state <= c_PCUPD;
                end
                c_PCUPD: begin
                    r_pc    <= w_next_pc;
                    r_state <= c_FETCH;
                end
                c_HALT: begin
                    r_state <= c_HALT;
                end
                default: begin
                    r_state  <= c_IDLE;
                    r_busy   <= 1'b0;
                    r_halted <= 1'b0;
                    r_m_req  <= 1'b0;
                end
            endcase
        end
    end

    assign PC     = r_pc;
    assign stat   = r_stat;
    assign d_en   = r_d_en;
    assign e_en   = r_e_en;
    assign w_en   = r_w_en;
    assign m_req  = r_m_req;
    assign busy   = r_busy;
    assign halted = r_halted;

`ifdef SEQ_CTRL_PERF_EN
    logic [31:0] r_instr_cnt;
    logic [31:0] r_cycle_cnt;

    // Retired-instruction and busy-cycle counters; both stop once busy falls in HALT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr_cnt <= 32'd0;
            r_cycle_cnt <= 32'd0;
        end else begin
            if (r_state == c_PCUPD) begin
                r_instr_cnt <= r_instr_cnt + 32'd1;
            end
            if (r_busy) begin
                r_cycle_cnt <= r_cycle_cnt + 32'd1;
            end
        end
    end

    assign instr_cnt = r_instr_cnt;
    assign cycle_cnt = r_cycle_cnt;
`else
    assign instr_cnt = 32'd0;
    assign cycle_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_controller
// Description : Self-checking bench for seq_controller: directed scenarios
//               with literal expectations, then randomized traffic compared
//               every cycle against an instruction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_controller;

    localparam logic [63:0] c_START_PC = 64'd0;
    localparam int          c_TIMEOUT  = 4;
`ifdef SEQ_CTRL_PERF_EN
    localparam bit          c_PERF     = 1'b1;
`else
    localparam bit          c_PERF     = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  stat_f;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] valC;
    logic [63:0] valP;
    logic [63:0] valM;
    logic        m_ack;
    logic        m_err;
    logic [63:0] PC;
    logic        d_en;
    logic        e_en;
    logic        w_en;
    logic        m_req;
    logic [3:0]  stat;
    logic        busy;
    logic        halted;
    logic [31:0] instr_cnt;
    logic [31:0] cycle_cnt;

    seq_controller #(
        .START_PC    (c_START_PC),
        .MEM_TIMEOUT (c_TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stat_f    (stat_f),
        .icode     (icode),
        .cnd       (cnd),
        .valC      (valC),
        .valP      (valP),
        .valM      (valM),
        .m_ack     (m_ack),
        .m_err     (m_err),
        .PC        (PC),
        .d_en      (d_en),
        .e_en      (e_en),
        .w_en      (w_en),
        .m_req     (m_req),
        .stat      (stat),
        .busy      (busy),
        .halted    (halted),
        .instr_cnt (instr_cnt),
        .cycle_cnt (cycle_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: run mode (0 idle, 1 running, 2 halted) plus the
    // position inside the current instruction (0 fetch .. 5 pc update).
    int          m_mode;
    int          m_step;
    bit          m_memop;
    int          m_wait;
    logic [63:0] m_pc;
    logic [3:0]  m_stat;
    logic [31:0] m_instr;
    logic [31:0] m_cycles;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode   = 0;
        m_step   = 0;
        m_memop  = 1'b0;
        m_wait   = 0;
        m_pc     = c_START_PC;
        m_stat   = 4'd0;
        m_instr  = 32'd0;
        m_cycles = 32'd0;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge
    task automatic model_step();
        if (reset) begin
            model_reset();
            return;
        end
        if (m_mode == 1) m_cycles++;
        if (m_mode == 0) begin
            if (start) begin
                m_mode = 1;
                m_step = 0;
            end
        end else if (m_mode == 1) begin
            case (m_step)
                0: begin
                    if (stat_f != 4'd0) begin
                        m_mode = 2;
                        m_stat = stat_f;
                    end else begin
                        m_step = 1;
                    end
                end
                1: m_step = 2;
                2: begin
                    m_step  = 3;
                    m_memop = icode inside {4, 5, 8, 9, 10, 11};
                    m_wait  = 0;
                end
                3: begin
                    if (!m_memop) begin
                        m_step = 4;
                    end else if (m_ack) begin
                        if (m_err) begin
                            m_mode = 2;
                            m_stat = 4'd2;
                        end else begin
                            m_step = 4;
                        end
                    end else begin
                        m_wait++;
                        if (m_wait >= c_TIMEOUT) begin
                            m_mode = 2;
                            m_stat = 4'd2;
                        end
                    end
                end
                4: m_step = 5;
                default: begin
                    if (icode == 4'd8 || (icode == 4'd7 && cnd)) m_pc = valC;
                    else if (icode == 4'd9)                      m_pc = valM;
                    else                                         m_pc = valP;
                    m_instr++;
                    m_step = 0;
                end
            endcase
        end
    endtask

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        chk("pc",        PC,              m_pc);
        chk("stat",      64'(stat),       64'(m_stat));
        chk("busy",      64'(busy),       64'(m_mode == 1));
        chk("halted",    64'(halted),     64'(m_mode == 2));
        chk("d_en",      64'(d_en),       64'(m_mode == 1 && m_step == 1));
        chk("e_en",      64'(e_en),       64'(m_mode == 1 && m_step == 2));
        chk("w_en",      64'(w_en),       64'(m_mode == 1 && m_step == 4));
        chk("m_req",     64'(m_req),      64'(m_mode == 1 && m_step == 3 && m_memop));
        chk("instr_cnt", 64'(instr_cnt),  c_PERF ? 64'(m_instr) : 64'd0);
        chk("cycle_cnt", 64'(cycle_cnt),  c_PERF ? 64'(m_cycles) : 64'd0);
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        tick();
        tick();
        reset = 1'b0;
    endtask

    int n_req;
    int wen_tick;
    bit d_seen;

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        stat_f = 4'd0;
        icode  = 4'd1;
        cnd    = 1'b0;
        valC   = 64'd0;
        valP   = 64'd0;
        valM   = 64'd0;
        m_ack  = 1'b0;
        m_err  = 1'b0;
        model_reset();
        tick();
        tick();
        reset = 1'b0;

        // Reset state and idle without start
        tick();
        chk("rst_busy",   64'(busy),   64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_pc",     PC,          64'd0);
        chk("rst_stat",   64'(stat),   64'd0);

        // nop program: PC 0,1,2 at FETCH entry, six cycles per instruction
        valP  = 64'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("nop_fetch_pc0", PC, 64'd0);
        chk("nop_busy",      64'(busy), 64'd1);
        tick();
        chk("nop_d_en", 64'(d_en), 64'd1);
        repeat (4) tick();
        chk("nop_pc0_hold", PC, 64'd0);
        tick();
        chk("nop_pc1", PC, 64'd1);
        valP = 64'd2;
        repeat (6) tick();
        chk("nop_pc2",       PC,              64'd2);
        chk("nop_instr_cnt", 64'(instr_cnt),  c_PERF ? 64'd2 : 64'd0);
        chk("nop_cycle_cnt", 64'(cycle_cnt),  c_PERF ? 64'd12 : 64'd0);

        // jXX taken and not taken
        icode = 4'd7;
        cnd   = 1'b1;
        valC  = 64'h40;
        valP  = 64'h33;
        repeat (6) tick();
        chk("jxx_taken", PC, 64'h40);
        cnd  = 1'b0;
        valC = 64'h77;
        valP = 64'h09;
        repeat (6) tick();
        chk("jxx_not_taken", PC, 64'h09);

        // mrmovq with ack on the fourth MEMORY cycle
        icode    = 4'd5;
        valP     = 64'h100;
        m_ack    = 1'b0;
        n_req    = 0;
        wen_tick = 0;
        for (int t = 1; t <= 9; t++) begin
            tick();
            if (m_req) n_req++;
            if (w_en) wen_tick = t;
            if (t == 8) chk("mr_pc_hold", PC, 64'h09);
            m_ack = (t == 6);
        end
        chk("mr_req_cycles", 64'(n_req),    64'd4);
        chk("mr_wen_tick",   64'(wen_tick), 64'd7);
        chk("mr_pc",         PC,            64'h100);

        // Memory never answers: timeout after four wait cycles
        icode = 4'd4;
        valP  = 64'h200;
        m_ack = 1'b0;
        repeat (6) tick();
        chk("to_req_last",  64'(m_req),  64'd1);
        chk("to_not_yet",   64'(halted), 64'd0);
        tick();
        chk("to_halted",    64'(halted), 64'd1);
        chk("to_req_drop",  64'(m_req),  64'd0);
        chk("to_stat",      64'(stat),   64'd2);
        chk("to_busy",      64'(busy),   64'd0);
        chk("to_pc",        PC,          64'h100);

        // Fetch fault at PC 0x20, start while halted is ignored
        do_reset();
        icode  = 4'd1;
        valP   = 64'h20;
        stat_f = 4'd0;
        start  = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        chk("ins_pc_before", PC, 64'h20);
        stat_f = 4'd3;
        d_seen = 1'b0;
        tick();
        chk("ins_halted", 64'(halted), 64'd1);
        chk("ins_stat",   64'(stat),   64'd3);
        chk("ins_pc",     PC,          64'h20);
        stat_f = 4'd0;
        start  = 1'b1;
        repeat (4) begin
            tick();
            d_seen = d_seen | d_en;
        end
        start = 1'b0;
        chk("ins_no_d_en",   64'(d_seen), 64'd0);
        chk("ins_stay_halt", 64'(halted), 64'd1);
        chk("ins_stat_hold", 64'(stat),   64'd3);

        // Reset asserted mid-MEMORY with m_req high
        do_reset();
        icode = 4'd1;
        valP  = 64'h55;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        icode = 4'd4;
        m_ack = 1'b0;
        repeat (3) tick();
        chk("mid_req_before", 64'(m_req), 64'd1);
        chk("mid_pc_before",  PC,         64'h55);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("mid_req",   64'(m_req),     64'd0);
        chk("mid_pc",    PC,             c_START_PC);
        chk("mid_busy",  64'(busy),      64'd0);
        chk("mid_instr", 64'(instr_cnt), 64'd0);
        chk("mid_cycle", 64'(cycle_cnt), 64'd0);
        @(negedge clk);
        #1;
        reset = 1'b0;
        tick();
        chk("rel_idle", 64'(busy), 64'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rel_start", 64'(busy), 64'd1);

        // Randomized traffic, checked every cycle by the compare process
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            start  = ($urandom_range(0, 3) == 0);
            stat_f = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            icode  = 4'($urandom_range(0, 15));
            cnd    = 1'($urandom_range(0, 1));
            valC   = {$urandom, $urandom};
            valP   = {$urandom, $urandom};
            valM   = {$urandom, $urandom};
            m_ack  = ($urandom_range(0, 9) < 4);
            m_err  = ($urandom_range(0, 9) == 0);
            if ((m_mode == 2 && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0) begin
                reset = 1'b1;
                model_reset();
            end else begin
                reset = 1'b0;
            end
            tick();
        end
        reset = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
